// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Imported by the loader top and its timeout counter.
package loader_pkg;

    typedef enum logic [1:0] {
        SKIP    = 2'd0,
        COLLECT = 2'd1,
        CHK     = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int          BYTE_W       = 8;
    localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_prog_loader_if.sv
// Byte-in / word-out bus between UART receiver, loader and
// instruction memory.
interface uart_prog_loader_if #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 7
);
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic [WORD_W-1:0] o_word;
    logic              o_word_valid;
    logic [ADDR_W-1:0] o_addr;

    modport master (
        output i_rx_data, i_rx_done,
        input  o_word, o_word_valid, o_addr
    );

    modport slave (
        input  i_rx_data, i_rx_done,
        output o_word, o_word_valid, o_addr
    );
endinterface

// File: rtl/loader_timeout_ctr.sv
// Idle-cycle counter: fires once after CYC enabled cycles with no
// clear, then starts over.
module loader_timeout_ctr
    import loader_pkg::*;
#(
    parameter int CYC = 50
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clr,
    input  logic i_en,
    output logic o_fire
);

    localparam int CW = cw(CYC + 1);

    logic [CW-1:0] cnt;

    assign o_fire = i_en && !i_clr && (cnt == CW'(CYC - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            cnt <= '0;
        else if (i_clr || !i_en || o_fire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART byte stream -> instruction-memory word writer.
// Optional trailing checksum byte: define LOADER_CHECKSUM_EN.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int BYTES_PER_WORD = 4,
    parameter int SKIP_BYTES     = 2,
    parameter int MEM_WORDS      = 25,
    parameter bit MSB_FIRST      = 1'b1,
    parameter logic [8*BYTES_PER_WORD-1:0] HALT_WORD = HALT_DEFAULT,
    parameter int TIMEOUT_CYC    = 0
)(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_restart,
    uart_prog_loader_if.slave rx,
    output logic [BYTE_W-1:0] o_last_byte,
    output logic              o_busy,
    output logic              o_load_done,
    output logic              o_overflow,
    output logic              o_frame_err,
    output logic              o_chk_err
);

    localparam int WORD_W = BYTE_W * BYTES_PER_WORD;
    localparam int ADDR_W = $clog2(MEM_WORDS * BYTES_PER_WORD);
    localparam int KW     = cw(BYTES_PER_WORD);
    localparam int SW     = cw(SKIP_BYTES + 1);

    localparam logic [ADDR_W-1:0] LAST_ADDR =
        ADDR_W'((MEM_WORDS - 1) * BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(BYTES_PER_WORD);
    localparam logic [KW-1:0]     LAST_K = KW'(BYTES_PER_WORD - 1);

    localparam state_t START_ST = (SKIP_BYTES == 0) ? COLLECT : SKIP;
`ifdef LOADER_CHECKSUM_EN
    localparam state_t END_ST = CHK;
`else
    localparam state_t END_ST = DONE;
`endif

    state_t            state, state_n;
    logic [SW-1:0]     skip_cnt;
    logic [KW-1:0]     k;
    logic [KW-1:0]     lane;
    logic [ADDR_W-1:0] ptr;
    logic [WORD_W-1:0] acc, word_n;
    logic              last_k;
    logic              take, emit, skip_inc, ovf_set, to_fire;
`ifdef LOADER_CHECKSUM_EN
    logic              chk_take;
    logic [BYTE_W-1:0] xr;
`endif

    assign last_k = (k == LAST_K);
    assign lane   = MSB_FIRST ? (LAST_K - k) : k;
    assign o_busy = (k != '0);

    always_comb begin
        word_n = acc;
        word_n[lane*BYTE_W +: BYTE_W] = rx.i_rx_data;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            state <= START_ST;
        else
            state <= state_n;
    end

    always_comb begin
        state_n  = state;
        take     = 1'b0;
        emit     = 1'b0;
        skip_inc = 1'b0;
        ovf_set  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_take = 1'b0;
`endif
        unique case (state)
            SKIP: begin
                if (rx.i_rx_done) begin
                    skip_inc = 1'b1;
                    if (skip_cnt == SW'(SKIP_BYTES - 1))
                        state_n = COLLECT;
                end
            end
            COLLECT: begin
                if (rx.i_rx_done) begin
                    take = 1'b1;
                    if (last_k) begin
                        emit = 1'b1;
                        if (word_n == HALT_WORD || ptr == LAST_ADDR)
                            state_n = END_ST;
                    end
                end
            end
            CHK: begin
                if (rx.i_rx_done) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_take = 1'b1;
`endif
                    state_n = DONE;
                end
            end
            DONE: ovf_set = rx.i_rx_done;
            default: state_n = START_ST;
        endcase
        // A restart drops whatever byte arrives with it.
        if (i_restart)
            state_n = START_ST;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            skip_cnt        <= '0;
            k               <= '0;
            ptr             <= '0;
            acc             <= '0;
            rx.o_word       <= '0;
            rx.o_addr       <= '0;
            rx.o_word_valid <= 1'b0;
            o_last_byte     <= '0;
            o_load_done     <= 1'b0;
            o_overflow      <= 1'b0;
            o_frame_err     <= 1'b0;
        end else if (i_restart) begin
            skip_cnt        <= '0;
            k               <= '0;
            ptr             <= '0;
            acc             <= '0;
            rx.o_word       <= '0;
            rx.o_addr       <= '0;
            rx.o_word_valid <= 1'b0;
            o_last_byte     <= '0;
            o_load_done     <= 1'b0;
            o_overflow      <= 1'b0;
            o_frame_err     <= 1'b0;
        end else begin
            rx.o_word_valid <= emit;
            if (skip_inc)
                skip_cnt <= skip_cnt + 1'b1;
            if (take) begin
                o_last_byte <= rx.i_rx_data;
                acc         <= word_n;
                k           <= last_k ? '0 : k + 1'b1;
            end else if (to_fire) begin
                k           <= '0;
                o_frame_err <= 1'b1;
            end
            if (emit) begin
                rx.o_word <= word_n;
                rx.o_addr <= ptr;
                ptr       <= ptr + STEP;
            end
            if (state_n == DONE && state != DONE)
                o_load_done <= 1'b1;
            if (ovf_set)
                o_overflow <= 1'b1;
        end
    end

    generate
        if (TIMEOUT_CYC > 0) begin : g_to
            loader_timeout_ctr #(
                .CYC (TIMEOUT_CYC)
            ) u_to (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_clr   (rx.i_rx_done | i_restart),
                .i_en    (state == COLLECT && k != '0),
                .o_fire  (to_fire)
            );
        end else begin : g_no_to
            assign to_fire = 1'b0;
        end
    endgenerate

`ifdef LOADER_CHECKSUM_EN
    // Running XOR covers every payload byte, halt word included.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            xr        <= '0;
            o_chk_err <= 1'b0;
        end else if (i_restart) begin
            xr        <= '0;
            o_chk_err <= 1'b0;
        end else begin
            if (take)
                xr <= xr ^ rx.i_rx_data;
            if (chk_take && rx.i_rx_data != xr)
                o_chk_err <= 1'b1;
        end
    end
`else
    assign o_chk_err = 1'b0;
`endif

endmodule
